vrf_wb_queue: RTL and testbench

Writeback queue at the output of the vector ALU: captures each valid ALU result together with its destination base address, buffers it in a small FIFO, and writes it into the vector register file write port with per-element address offsets. It also counts elements against the programmed vector length and pulses `done` when the whole vector is retired. It sits between the ALU result bus and the VRF write port, and is the consumer end of the ALU's result/valid/address protocol.

---
 rtl/vrf_wb_pkg.sv | 17 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/vrf_wb_queue.sv | 99 +++++++++
 tb/tb_vrf_wb_queue.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_wb_pkg.sv
// Shared types and constants for the VRF writeback queue.
package vrf_wb_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;

  // The ALU drives this pattern on bubbles; it is never a real result.
  localparam logic [31:0] VALU_INVALID = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wbq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with separate occupancy count so full/empty never alias.
module sync_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

  // Storage is left unreset; the head is masked by empty at the consumer.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vrf_wb_queue.sv
// Buffers valid ALU results and writes them to the VRF at base+element offsets,
// retiring the vector with a one-cycle done pulse.
module vrf_wb_queue
  import vrf_wb_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [7:0]        vl,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              full,
  output logic              vrf_we,
  output logic [ADDR_W-1:0] vrf_waddr,
  output logic [DATA_W-1:0] vrf_wdata,
  input  logic              vrf_wready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [CW-1:0]     count
);

  wbq_state_t               state;
  logic [7:0]               vl_q;
  logic [7:0]               push_idx;
  logic [7:0]               wr_cnt;
  logic                     qualify;
  logic                     push;
  logic                     pop;
  logic                     fifo_empty;
  logic [ADDR_W-1:0]        elem_addr;
  logic [DATA_W+ADDR_W-1:0] head;

  assign qualify   = (state == RUN) && in_valid &&
                     (in_data != DATA_W'(VALU_INVALID)) && (push_idx < vl_q);
  assign push      = qualify && !full;
  assign pop       = vrf_we && vrf_wready;
  assign elem_addr = in_addr + ADDR_W'(push_idx);

  assign vrf_we    = !fifo_empty;
  assign vrf_waddr = fifo_empty ? '0 : head[ADDR_W-1:0];
  assign vrf_wdata = fifo_empty ? '0 : head[DATA_W+ADDR_W-1:ADDR_W];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  sync_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .wdata ({in_data, elem_addr}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  // Retirement is judged on the write that brings wr_cnt up to vl_q.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= IDLE;
      vl_q     <= '0;
      push_idx <= '0;
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) wr_cnt <= wr_cnt + 8'd1;
      if (push) push_idx <= push_idx + 8'd1;
      if (qualify && full) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            vl_q     <= vl;
            push_idx <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
            state    <= (vl != 8'd0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (pop && (wr_cnt + 8'd1 == vl_q)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vrf_wb_queue.sv
// Directed self-checking bench for vrf_wb_queue.
module tb_vrf_wb_queue;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [7:0]  vl;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_addr;
  logic        full;
  logic        vrf_we;
  logic [7:0]  vrf_waddr;
  logic [31:0] vrf_wdata;
  logic        vrf_wready;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [3:0]  count;

  int checks;
  int errors;

  vrf_wb_queue dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .vl         (vl),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .full       (full),
    .vrf_we     (vrf_we),
    .vrf_waddr  (vrf_waddr),
    .vrf_wdata  (vrf_wdata),
    .vrf_wready (vrf_wready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] len, input logic [7:0] base);
    start   = 1'b1;
    vl      = len;
    in_addr = base;
    next_cycle();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    next_cycle();
    next_cycle();
    checks++;
    if ({vrf_we, vrf_waddr, vrf_wdata, full, busy, done, overflow, count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got we=%b addr=%h data=%h full=%b busy=%b done=%b ovf=%b cnt=%0d want all 0",
               vrf_we, vrf_waddr, vrf_wdata, full, busy, done, overflow, count);
    end
    nrst = 1'b1;
    next_cycle();
  endtask

  task automatic test_streaming();
    vrf_wready = 1'b1;
    start_op(8'd4, 8'h10);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stream_busy got %b want 1", busy);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'(i + 1);
      next_cycle();
      checks++;
      if (vrf_we !== 1'b1 || vrf_waddr !== 8'(8'h10 + i) || vrf_wdata !== 32'(i + 1) || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stream_write%0d got we=%b addr=%h data=%h done=%b want we=1 addr=%h data=%h done=0",
                 i, vrf_we, vrf_waddr, vrf_wdata, done, 8'(8'h10 + i), 32'(i + 1));
      end
    end
    in_valid = 1'b0;
    next_cycle();
    checks++;
    if (done !== 1'b1 || vrf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_done got done=%b we=%b want done=1 we=0", done, vrf_we);
    end
    next_cycle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    vrf_wready = 1'b0;
    start_op(8'd10, 8'h20);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'(100 + i);
      next_cycle();
      if (i == 7) begin
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_full_at8 got full=%b ovf=%b want full=1 ovf=0", full, overflow);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_overflow got full=%b cnt=%0d ovf=%b want 1 8 1", full, count, overflow);
    end
    // A start while RUN must be ignored and must not clear overflow.
    start = 1'b1;
    vl    = 8'd1;
    next_cycle();
    start = 1'b0;
    next_cycle();
    checks++;
    if (overflow !== 1'b1 || busy !== 1'b1 || vrf_waddr !== 8'h20 || vrf_wdata !== 32'd100) begin
      errors++;
      $display("[TB] FAIL bp_hold got ovf=%b busy=%b addr=%h data=%0d want 1 1 20 100",
               overflow, busy, vrf_waddr, vrf_wdata);
    end
    vrf_wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (vrf_we !== 1'b1 || vrf_waddr !== 8'(8'h20 + i) || vrf_wdata !== 32'(100 + i)) begin
        errors++;
        $display("[TB] FAIL bp_drain%0d got we=%b addr=%h data=%0d want we=1 addr=%h data=%0d",
                 i, vrf_we, vrf_waddr, vrf_wdata, 8'(8'h20 + i), 100 + i);
      end
      next_cycle();
    end
    next_cycle();
    checks++;
    if (vrf_we !== 1'b0 || count !== 4'd0 || done !== 1'b0 || busy !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_after got we=%b cnt=%0d done=%b busy=%b full=%b want 0 0 0 1 0",
               vrf_we, count, done, busy, full);
    end
    nrst = 1'b0;
    next_cycle();
    nrst = 1'b1;
    next_cycle();
  endtask

  task automatic test_sentinel();
    logic [31:0] seq [4];
    seq[0] = 32'd5;
    seq[1] = 32'hDEAD_DEAD;
    seq[2] = 32'd6;
    seq[3] = 32'd7;
    vrf_wready = 1'b0;
    start_op(8'd2, 8'h40);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = seq[i];
      next_cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd2 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sent_count got cnt=%0d ovf=%b want 2 0", count, overflow);
    end
    vrf_wready = 1'b1;
    checks++;
    if (vrf_waddr !== 8'h40 || vrf_wdata !== 32'd5) begin
      errors++;
      $display("[TB] FAIL sent_first got addr=%h data=%h want 40 5", vrf_waddr, vrf_wdata);
    end
    next_cycle();
    checks++;
    if (vrf_we !== 1'b1 || vrf_waddr !== 8'h41 || vrf_wdata !== 32'd6) begin
      errors++;
      $display("[TB] FAIL sent_second got we=%b addr=%h data=%h want 1 41 6", vrf_we, vrf_waddr, vrf_wdata);
    end
    next_cycle();
    checks++;
    if (done !== 1'b1 || vrf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sent_done got done=%b we=%b want 1 0", done, vrf_we);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr;
    vrf_wready = 1'b1;
    start_op(8'd3, 8'hFE);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data  = 32'(8'hA0 + i);
      exp_addr = 8'hFE + 8'(i);
      next_cycle();
      checks++;
      if (vrf_we !== 1'b1 || vrf_waddr !== exp_addr || vrf_wdata !== 32'(8'hA0 + i)) begin
        errors++;
        $display("[TB] FAIL wrap_addr%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 i, vrf_we, vrf_waddr, vrf_wdata, exp_addr, 32'(8'hA0 + i));
      end
    end
    in_valid = 1'b0;
    next_cycle();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_done got %b want 1", done);
    end
    next_cycle();
  endtask

  task automatic test_vl_zero();
    start_op(8'd0, 8'h60);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || vrf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL vl0_done got done=%b busy=%b we=%b want 1 1 0", done, busy, vrf_we);
    end
    in_valid = 1'b1;
    in_data  = 32'd9;
    next_cycle();
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || count !== 4'd0 || vrf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL vl0_idle got done=%b busy=%b cnt=%0d we=%b want 0 0 0 0", done, busy, count, vrf_we);
    end
  endtask

  task automatic test_mid_reset();
    vrf_wready = 1'b0;
    start_op(8'd5, 8'h30);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'(i + 20);
      next_cycle();
    end
    in_valid = 1'b0;
    checks++;
    if (count !== 4'd3 || vrf_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_queued got cnt=%0d we=%b want 3 1", count, vrf_we);
    end
    nrst = 1'b0;
    next_cycle();
    nrst = 1'b1;
    checks++;
    if (count !== 4'd0 || vrf_we !== 1'b0 || busy !== 1'b0 || vrf_waddr !== 8'h00) begin
      errors++;
      $display("[TB] FAIL mid_flush got cnt=%0d we=%b busy=%b addr=%h want 0 0 0 00",
               count, vrf_we, busy, vrf_waddr);
    end
    vrf_wready = 1'b1;
    start_op(8'd2, 8'h50);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_data = 32'(8'h11 * (i + 1));
      next_cycle();
      checks++;
      if (vrf_we !== 1'b1 || vrf_waddr !== 8'(8'h50 + i) || vrf_wdata !== 32'(8'h11 * (i + 1))) begin
        errors++;
        $display("[TB] FAIL mid_rerun%0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 i, vrf_we, vrf_waddr, vrf_wdata, 8'(8'h50 + i), 32'(8'h11 * (i + 1)));
      end
    end
    in_valid = 1'b0;
    next_cycle();
    checks++;
    if (done !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_rerun_done got done=%b ovf=%b want 1 0", done, overflow);
    end
    next_cycle();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    nrst       = 1'b0;
    start      = 1'b0;
    vl         = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_addr    = '0;
    vrf_wready = 1'b0;
    #1;
    $display("[TB] starting vrf_wb_queue bench");
    test_reset();
    test_streaming();
    test_backpressure();
    test_sentinel();
    test_wrap();
    test_vl_zero();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
